// File: rtl/irda_tx_frame_seq.sv
// MIR/FIR transmit frame sequencer: preamble, start flag, data, CRC and stop flag, one field bit per line tick.
// Build option: define IRDA_TX_CRC_EN to generate the CRC field; otherwise DATA proceeds directly to STOP.
module irda_tx_frame_seq #(
    parameter int unsigned PRE_TICKS   = 64,
    parameter int unsigned START_TICKS = 16,
    parameter int unsigned STOP_TICKS  = 8,
    parameter int unsigned LEN_W       = 12
) (
    input  logic             clk,
    input  logic             wb_rst_n,
    input  logic             tx_start,
    input  logic             tx_abort,
    input  logic             mir_mode,
    input  logic             fir_mode,
    input  logic             mir_txbit_enable,
    input  logic             fir_tx4_enable,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             data_available,
    input  logic             data_i,
    output logic             dc_restart,
    output logic             next_data,
    output logic [2:0]       tx_field_o,
    output logic             tx_data_o,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_underrun
);

    localparam int unsigned BCNT_W = LEN_W + 3;
    localparam int unsigned MAX_T1 = (PRE_TICKS > START_TICKS) ? PRE_TICKS : START_TICKS;
    localparam int unsigned MAX_T2 = (MAX_T1 > STOP_TICKS) ? MAX_T1 : STOP_TICKS;
    localparam int unsigned MAX_T  = (MAX_T2 > 32) ? MAX_T2 : 32;
    localparam int unsigned FCNT_W = $clog2(MAX_T);

    localparam logic [2:0] FLD_IDLE  = 3'd0;
    localparam logic [2:0] FLD_PRE   = 3'd1;
    localparam logic [2:0] FLD_START = 3'd2;
    localparam logic [2:0] FLD_DATA  = 3'd3;
    localparam logic [2:0] FLD_STOP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_RESTART, S_FILL, S_PRE, S_START, S_DATA, S_CRC, S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic                fir_q, fir_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                dc_restart_q, dc_restart_d;
    logic                next_data_q, next_data_d;
    logic [2:0]          tx_field_q, tx_field_d;
    logic                tx_data_q, tx_data_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_done_q, tx_done_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                tick_c;
    logic                accept_c;
    logic                kill_c;

`ifdef IRDA_TX_CRC_EN
    localparam logic [2:0]  FLD_CRC    = 3'd4;
    localparam logic [31:0] CRC16_POLY = 32'h0000_8408;
    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;

    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_upd;
    logic        crc_last;

    // Reflected CRC step: MIR keeps its 16-bit register in the low half.
    assign crc_upd  = (crc_q >> 1) ^ (((crc_q[0] ^ data_i) != 1'b0) ?
                                      (fir_q ? CRC32_POLY : CRC16_POLY) : 32'h0);
    assign crc_last = (fcnt_q == (fir_q ? FCNT_W'(31) : FCNT_W'(15)));
`endif

    assign tick_c   = fir_q ? fir_tx4_enable : mir_txbit_enable;
    assign accept_c = tx_start && !tx_abort && (mir_mode != fir_mode);

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        fir_d         = fir_q;
        bcnt_d        = bcnt_q;
        fcnt_d        = fcnt_q;
        dc_restart_d  = 1'b0;
        next_data_d   = 1'b0;
        tx_field_d    = tx_field_q;
        tx_data_d     = tx_data_q;
        tx_done_d     = 1'b0;
        tx_underrun_d = 1'b0;
`ifdef IRDA_TX_CRC_EN
        crc_d         = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_field_d = FLD_IDLE;
                tx_data_d  = 1'b0;
                if (accept_c) begin
                    state_d      = S_RESTART;
                    fir_d        = fir_mode;
                    bcnt_d       = {frame_len, 3'b000};
                    dc_restart_d = 1'b1;
                end
            end
            S_RESTART: begin
                fcnt_d  = '0;
`ifdef IRDA_TX_CRC_EN
                crc_d   = fir_q ? 32'hFFFF_FFFF : 32'h0000_FFFF;
`endif
                state_d = S_FILL;
            end
            S_FILL: begin
                if (data_available || (bcnt_q == '0)) begin
                    state_d = fir_q ? S_PRE : S_START;
                end
            end
            S_PRE: begin
                if (tick_c) begin
                    tx_field_d = FLD_PRE;
                    tx_data_d  = 1'b0;
                    if (fcnt_q == FCNT_W'(PRE_TICKS - 1)) begin
                        fcnt_d  = '0;
                        state_d = S_START;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            S_START: begin
                if (tick_c) begin
                    tx_field_d = FLD_START;
                    tx_data_d  = 1'b0;
                    if (fcnt_q == FCNT_W'(START_TICKS - 1)) begin
                        fcnt_d = '0;
                        if (bcnt_q != '0) begin
                            state_d = S_DATA;
                        end else begin
`ifdef IRDA_TX_CRC_EN
                            state_d = S_CRC;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    if (!data_available) begin
                        tx_underrun_d = 1'b1;
                    end else begin
                        tx_field_d  = FLD_DATA;
                        tx_data_d   = data_i;
                        next_data_d = 1'b1;
                        bcnt_d      = bcnt_q - BCNT_W'(1);
`ifdef IRDA_TX_CRC_EN
                        crc_d       = crc_upd;
                        if (bcnt_q == BCNT_W'(1)) state_d = S_CRC;
`else
                        if (bcnt_q == BCNT_W'(1)) state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef IRDA_TX_CRC_EN
            S_CRC: begin
                if (tick_c) begin
                    tx_field_d = FLD_CRC;
                    tx_data_d  = ~crc_q[0];
                    crc_d      = crc_q >> 1;
                    if (crc_last) begin
                        fcnt_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick_c) begin
                    tx_field_d = FLD_STOP;
                    tx_data_d  = 1'b0;
                    if (fcnt_q == FCNT_W'(STOP_TICKS - 1)) begin
                        fcnt_d    = '0;
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort and underrun both drop the frame and restart the data controller
        kill_c = (tx_abort && (state_q != S_IDLE)) || tx_underrun_d;
        if (kill_c) begin
            state_d      = S_IDLE;
            fcnt_d       = '0;
            dc_restart_d = 1'b1;
            next_data_d  = 1'b0;
            tx_field_d   = FLD_IDLE;
            tx_data_d    = 1'b0;
            tx_done_d    = 1'b0;
        end

        tx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q       <= S_IDLE;
            fir_q         <= 1'b0;
            bcnt_q        <= '0;
            fcnt_q        <= '0;
            dc_restart_q  <= 1'b0;
            next_data_q   <= 1'b0;
            tx_field_q    <= FLD_IDLE;
            tx_data_q     <= 1'b0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
`ifdef IRDA_TX_CRC_EN
            crc_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fir_q         <= fir_d;
            bcnt_q        <= bcnt_d;
            fcnt_q        <= fcnt_d;
            dc_restart_q  <= dc_restart_d;
            next_data_q   <= next_data_d;
            tx_field_q    <= tx_field_d;
            tx_data_q     <= tx_data_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
            tx_underrun_q <= tx_underrun_d;
`ifdef IRDA_TX_CRC_EN
            crc_q         <= crc_d;
`endif
        end
    end

    assign dc_restart  = dc_restart_q;
    assign next_data   = next_data_q;
    assign tx_field_o  = tx_field_q;
    assign tx_data_o   = tx_data_q;
    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: doc/irda_tx_frame_seq.md
Name: irda_tx_frame_seq

Overview:
- Transmit frame sequencer for the MIR/FIR paths. Drives the TX data controller's restart and next-bit strobes, and walks the frame fields: preamble (FIR only), start flag, data, CRC, stop flag.
- Emits one field code and one data/CRC bit per line tick to the downstream MIR/FIR encoders.
- Sits between the Wishbone control registers and the data controller / encoders.

Parameters:
PRE_TICKS, 64, FIR preamble length in ticks (MIR: no preamble)
START_TICKS, 16, start-flag field length in ticks
STOP_TICKS, 8, stop-flag field length in ticks
LEN_W, 12, width of frame_len (bytes)

Ports:
clk  in  1  system clock
wb_rst_n  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle frame start request
tx_abort  in  1  one-cycle abort request
mir_mode  in  1  MIR mode select
fir_mode  in  1  FIR mode select
mir_txbit_enable  in  1  MIR bit tick
fir_tx4_enable  in  1  FIR bit tick
frame_len  in  LEN_W  payload length in bytes; sampled at start
data_available  in  1  data controller holds a valid bit
data_i  in  1  current payload bit from the data controller
dc_restart  out  1  one-cycle restart pulse to the data controller
next_data  out  1  one-cycle advance strobe to the data controller
tx_field_o  out  3  0 idle, 1 preamble, 2 start, 3 data, 4 crc, 5 stop
tx_data_o  out  1  bit for the current tick (data/crc fields; 0 otherwise)
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse on normal completion
tx_underrun  out  1  one-cycle pulse on data starvation

Behaviour:
- Reset: all outputs 0; state IDLE; counters and CRC cleared.
- Mode latch: mode is latched at an accepted tx_start. tx_start is ignored when mir_mode == fir_mode.
- Tick: mir_txbit_enable in MIR, fir_tx4_enable in FIR, using the latched mode. All field progress occurs only on ticks.
- States: IDLE, RESTART, FILL, PRE, START, DATA, CRC, STOP.
- IDLE: an accepted tx_start moves to RESTART; tx_busy rises the next cycle.
- RESTART: dc_restart=1 for exactly one cycle; CRC preset to all-ones; bit counter loaded with 8*frame_len; then FILL.
- FILL: wait until data_available=1 or bit count==0, then go to PRE (FIR) or START (MIR). There is no timeout.
- PRE / START / STOP: the field counter counts ticks. PRE lasts PRE_TICKS ticks, START lasts START_TICKS, STOP lasts STOP_TICKS. The field changes on the tick that completes the count.
- START exits to DATA, or directly to CRC when frame_len==0.
- DATA, on each tick:
  - tx_data_o=data_i registered; CRC updated with data_i; next_data=1 for that cycle; counter decremented.
  - The tick consuming the last bit exits to CRC.
- Underrun: a tick in DATA with data_available=0 sends no bit, pulses tx_underrun, and then behaves as tx_abort.
- CRC field:
  - MIR: CRC-16 reflected (poly 0x1021), 16 ticks.
  - FIR: CRC-32 reflected (poly 0x04C11DB7), 32 ticks.
  - Output is the ones-complement of the register, LSB first. Then STOP.
- STOP end: tx_done pulses one cycle; return to IDLE; tx_busy falls in the same cycle.
- tx_abort, any non-IDLE state: next cycle IDLE; dc_restart pulses one cycle; tx_field_o=0; no tx_done.
- Priority and concurrency:
  - tx_abort beats tx_start and ticks in the same cycle.
  - tx_start while busy is ignored.
  - A mode-input change mid-frame is ignored.
- Registering: tx_field_o and tx_data_o are registered and update in the cycle after the tick; they hold between ticks.
- Counter width: the bit counter is LEN_W+3 bits; frame_len=max gives no wrap.

Optional Feature:
- Macro: IRDA_TX_CRC_EN.
- Defined: CRC field generated as above.
- Undefined:
  - CRC logic is removed.
  - DATA exits straight to STOP.
  - frame_len==0 goes START to STOP.
  - Field code 4 is never emitted.

Test Plan:
- MIR, frame_len=9, payload "123456789" (0x31..0x39, LSB first):
  - Field sequence: start 16 ticks, data 72 ticks, crc 16 ticks, stop 8 ticks.
  - CRC bits are 0x6E then 0x90, LSB first.
  - tx_done is pulsed once; exactly 72 next_data pulses.
- FIR, same payload: preamble 64 ticks; CRC bits 0xCBF43926, LSB first (0x26 first); 32 crc ticks.
- MIR, frame_len=0: start to crc (value 0x0000 sent as complement of 0xFFFF... i.e. 16 zero bits) to stop; zero next_data pulses.
- Underrun: drop data_available at data bit 20 → tx_underrun pulse, one dc_restart pulse, IDLE next cycle, no tx_done.
- tx_abort and tx_start in the same cycle during CRC → IDLE, no new frame; a later tx_start starts cleanly with dc_restart=1.
- mir_mode=fir_mode=1, tx_start → no state change; reset asserted mid-DATA → all outputs 0 immediately.
